// File: rtl/seqpu_pkg.sv
// Shared constants and helpers for the seqpu memory/I-O stage.
package seqpu_pkg;

  localparam logic [15:0] ADDR_TXDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_STATUS = 16'hFFF1;
  localparam logic [15:0] ADDR_CYCLE  = 16'hFFF2;

  localparam int unsigned STAT_OVF   = 15;
  localparam int unsigned STAT_FULL  = 14;
  localparam int unsigned STAT_EMPTY = 13;
  localparam int unsigned STAT_CNT_W = 7;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CYCLE
  } sel_e;

  function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                              input logic empty,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [15:0] s;
    s = '0;
    s[STAT_OVF]           = ovf;
    s[STAT_FULL]          = full;
    s[STAT_EMPTY]         = empty;
    s[STAT_CNT_W-1:0]     = cnt;
    return s;
  endfunction

endpackage

// File: rtl/seqpu_tx_fifo.sv
// Synchronous transmit FIFO with registered head word and sticky overflow flag.
module seqpu_tx_fifo
  import seqpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  ready,
  input  logic                  ovf_clr,
  output logic [W-1:0]          dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic [STAT_CNT_W-1:0] count,
  output logic                  overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt, cnt_nxt, remain;
  logic [W-1:0]  head_nxt;
  logic          pop, push_ok, drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign valid = !empty;
  assign count = STAT_CNT_W'(cnt);

  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (!push_ok && pop)
      cnt_nxt = cnt - CW'(1);
    rd_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    remain = pop ? cnt - CW'(1) : cnt;
    // Head is precomputed so tx_data comes straight from a flop; a push
    // into an otherwise-empty queue bypasses the storage array.
    head_nxt = dout;
    if (remain != '0)
      head_nxt = mem[rd_nxt];
    else if (push_ok)
      head_nxt = din;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      dout   <= head_nxt;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/seqpu_mem_io.sv
// seqpu memory and I/O stage: word RAM, TX FIFO, status and cycle counter
// behind a one-cycle-latency read port.
module seqpu_mem_io
  import seqpu_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter string       INIT_FILE  = "",
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        wren_n,
  output logic [15:0] data_in,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [15:0]           ram [RAM_WORDS];
  logic [15:0]           cyc;
  logic [15:0]           rd_val;
  logic                  wr;
  sel_e                  sel;
  logic                  fifo_full, fifo_empty, fifo_ovf;
  logic [STAT_CNT_W-1:0] fifo_count;

  assign wr = !wren_n && !rst;

  always_comb begin
    sel = SEL_NONE;
    if (32'(address) < RAM_WORDS)
      sel = SEL_RAM;
    else if (address == ADDR_TXDATA)
      sel = SEL_TX;
    else if (address == ADDR_STATUS)
      sel = SEL_STATUS;
    else if (address == ADDR_CYCLE)
      sel = SEL_CYCLE;
  end

  seqpu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr && sel == SEL_TX),
    .din      (data_out),
    .ready    (tx_ready),
    .ovf_clr  (wr && sel == SEL_STATUS),
    .dout     (tx_data),
    .valid    (tx_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_comb begin
    rd_val = '0;
    unique case (sel)
      SEL_RAM:    rd_val = ram[address[AW-1:0]];
      SEL_TX:     rd_val = tx_data;
      SEL_STATUS: rd_val = status_word(fifo_ovf, fifo_full, fifo_empty, fifo_count);
      SEL_CYCLE:  rd_val = cyc;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr && sel == SEL_RAM)
      ram[address[AW-1:0]] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_in <= '0;
      cyc     <= '0;
    end else begin
      data_in <= rd_val;
      // A load still counts the cycle it happens in, so the loaded value
      // is already one ahead when first observed.
      if (wr && sel == SEL_CYCLE)
        cyc <= data_out + 16'd1;
      else
        cyc <= cyc + 16'd1;
    end
  end

endmodule

// File: tb/tb_seqpu_mem_io.sv
// Randomised scoreboard bench for seqpu_mem_io against a queue-based reference model.
module tb_seqpu_mem_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wren_n;
  logic [15:0] data_in;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  seqpu_mem_io #(
    .RAM_WORDS  (1024),
    .INIT_FILE  (""),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_out (data_out),
    .wren_n   (wren_n),
    .data_in  (data_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_din;
    logic [15:0] din;
    logic        txv;
    logic        chk_txd;
    logic [15:0] txd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [15:0] ram_m [int];
  logic [15:0] fifo_m[$];
  logic        ovf_m;
  logic [15:0] cyc_m;
  logic [15:0] head_m;
  logic        head_known;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t predict_read(input logic [15:0] a);
    exp_t e;
    e.chk_din = 1'b1;
    e.din     = 16'h0000;
    e.txv     = 1'b0;
    e.chk_txd = 1'b0;
    e.txd     = 16'h0000;
    if (a < 16'd1024) begin
      if (ram_m.exists(int'(a))) e.din = ram_m[int'(a)];
      else e.chk_din = 1'b0;
    end else if (a == 16'hFFF0) begin
      e.din     = head_m;
      e.chk_din = head_known;
    end else if (a == 16'hFFF1) begin
      e.din = {ovf_m, fifo_m.size() == 8, fifo_m.size() == 0, 6'b0, 7'(fifo_m.size())};
    end else if (a == 16'hFFF2) begin
      e.din = cyc_m;
    end
    return e;
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                      input logic rdy, input logic rs);
    exp_t e;
    bit   do_pop;
    bit   was_full;
    @(negedge clk);
    address  = a;
    data_out = d;
    wren_n   = ~w;
    tx_ready = rdy;
    rst      = rs;
    @(posedge clk);
    if (rs) begin
      e.chk_din = 1'b1;
      e.din     = 16'h0000;
      fifo_m.delete();
      ovf_m      = 1'b0;
      cyc_m      = 16'h0000;
      head_m     = 16'h0000;
      head_known = 1'b1;
    end else begin
      e        = predict_read(a);
      was_full = (fifo_m.size() == 8);
      do_pop   = (fifo_m.size() > 0) && rdy;
      if (do_pop) void'(fifo_m.pop_front());
      cyc_m = cyc_m + 16'd1;
      if (w) begin
        if (a < 16'd1024) ram_m[int'(a)] = d;
        else if (a == 16'hFFF0) begin
          if (was_full && !do_pop) ovf_m = 1'b1;
          else fifo_m.push_back(d);
        end else if (a == 16'hFFF1) ovf_m = 1'b0;
        else if (a == 16'hFFF2) cyc_m = d + 16'd1;
      end
      if (fifo_m.size() > 0) begin
        head_m     = fifo_m[0];
        head_known = 1'b1;
      end
    end
    e.txv     = (fifo_m.size() > 0);
    e.chk_txd = e.txv || (head_known && head_m == 16'h0000 && rs);
    e.txd     = e.txv ? fifo_m[0] : 16'h0000;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_din) check("data_in", data_in, e.din);
        check("tx_valid", {15'b0, tx_valid}, {15'b0, e.txv});
        if (e.chk_txd) check("tx_data", tx_data, e.txd);
      end
    end
  end

  initial begin : stim
    logic [15:0] a;
    int          r;
    rst = 1'b1; address = 16'h0005; data_out = '0; wren_n = 1'b1; tx_ready = 1'b0;
    ovf_m = 1'b0; cyc_m = '0; head_m = '0; head_known = 1'b0;

    step(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    step(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);

    step(16'h0010, 16'h1111, 1'b1, 1'b0, 1'b0);
    step(16'h0010, 16'h1234, 1'b1, 1'b0, 1'b0);
    step(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 9; i++) step(16'hFFF0, 16'(i), 1'b1, 1'b0, 1'b0);
    step(16'hFFF1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'hFFF1, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(16'hFFF0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(16'hFFF1, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 8; i++) step(16'hFFF0, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0);
    step(16'hFFF0, 16'h00AA, 1'b1, 1'b1, 1'b0);
    step(16'hFFF1, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(16'hFFF0, 16'h0000, 1'b0, 1'b1, 1'b0);

    step(16'hFFF2, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(16'hFFF2, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step(16'hFFF0, 16'h0200 + 16'(i), 1'b1, 1'b0, 1'b0);
    step(16'hFFF0, 16'h0BAD, 1'b1, 1'b1, 1'b1);
    step(16'hFFF1, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 32; i++) step(16'(i), 16'($urandom), 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: a = 16'($urandom_range(0, 31));
        3, 4:    a = 16'hFFF0;
        5:       a = 16'hFFF1;
        6:       a = 16'hFFF2;
        7:       a = 16'hFFF0;
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 16'h0400;
            1:       a = 16'hFFF3;
            2:       a = 16'h8000;
            default: a = 16'hFFEF;
          endcase
        end
      endcase
      step(a, 16'($urandom), ($urandom_range(0, 2) != 0) && (r != 7),
           1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
